// File: rtl/regbank_ctrl_pkg.sv
// Shared types and default widths for the register-bank write-port controller.
package regbank_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i wins,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          any_grant_o
);

  logic [PW-1:0] idx;

  // Scan from the farthest candidate down so the closest one to ptr_i overrides.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        any_grant_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_write_ctrl.sv
// Write-port controller for the register bank: zero-clear sweep after reset or
// on request, then round-robin arbitration of writeback requesters.
module regbank_write_ctrl
  import regbank_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     CLEAR_REQ,
  input  logic [N_REQ-1:0]         REQ_VALID,
  input  logic [N_REQ*ADDR_W-1:0]  REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]         REQ_READY,
  output logic [ADDR_W-1:0]        WC,
  output logic [DATA_W-1:0]        WPC,
  output logic                     WC_Activator,
  output logic                     CLEAR_DONE,
  output state_t                   DBG_STATE
);

  localparam int PW = $clog2(N_REQ);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic [DATA_W-1:0] wpc_q, wpc_d;
  logic              wca_q, wca_d;
  logic              done_q, done_d;

  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  arb_grant;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;

  // Handshake: requester i holds REQ_VALID[i] with stable addr/data until a
  // cycle where REQ_VALID[i] && REQ_READY[i]; that cycle is the accept, and
  // the write appears on WC/WPC/WC_Activator at the following edge.
  // CLEAR_REQ masks all grants so nothing is accepted while the sweep is queued.
  assign arb_req = (state_q == ST_RUN && !CLEAR_REQ) ? REQ_VALID : '0;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_arb (
    .req_i       (arb_req),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_grant_o (arb_any)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      wc_q      <= '0;
      wpc_q     <= '0;
      wca_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      wc_q      <= wc_d;
      wpc_q     <= wpc_d;
      wca_q     <= wca_d;
      done_q    <= done_d;
    end
  end

  // The extra counter bit marks the tail cycle after the last sweep write.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q[ADDR_W]) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (CLEAR_REQ) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (arb_any) begin
          ptr_d = (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    wc_d   = wc_q;
    wpc_d  = wpc_q;
    wca_d  = 1'b0;
    done_d = (state_d == ST_RUN);
    if (state_q == ST_CLEAR && !clr_cnt_q[ADDR_W]) begin
      wc_d  = clr_cnt_q[ADDR_W-1:0];
      wpc_d = '0;
      wca_d = 1'b1;
    end else if (arb_any) begin
      wc_d  = REQ_ADDR[arb_idx*ADDR_W +: ADDR_W];
      wpc_d = REQ_DATA[arb_idx*DATA_W +: DATA_W];
      wca_d = 1'b1;
    end
  end

  assign REQ_READY    = arb_grant;
  assign WC           = wc_q;
  assign WPC          = wpc_q;
  assign WC_Activator = wca_q;
  assign CLEAR_DONE   = done_q;
  assign DBG_STATE    = state_q;

endmodule
